parallax_scroll_sequencer: RTL and testbench

PARALLAX_SCROLL_SEQUENCER -- requirements
Module: parallax_scroll_sequencer

---
 rtl/parallax_scroll_sequencer_pkg.sv | 22 ++
 rtl/parallax_scroll_sequencer_if.sv | 24 ++
 rtl/parallax_scroll_sequencer_layer_divider.sv | 44 ++++
 rtl/parallax_scroll_sequencer.sv | 110 +++++++++++
 tb/tb_parallax_scroll_sequencer.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/parallax_scroll_sequencer_pkg.sv
// Shared constants, reset period table and FSM state type for the parallax scroll sequencer.
package scroller_pkg;

    localparam int unsigned NUM_LAYERS = 4;
    localparam int unsigned PERIOD_W   = 4;
    localparam int unsigned IDX_W      = $clog2(NUM_LAYERS);

    localparam logic [PERIOD_W-1:0] PERIOD_OFF = 4'hF;

    // Layer k resets to period (2^k)-1, so deeper layers scroll progressively slower.
    localparam logic [NUM_LAYERS*PERIOD_W-1:0] RESET_PERIODS = {4'd7, 4'd3, 4'd1, 4'd0};

    typedef enum logic [0:0] {
        StIdle,
        StScan
    } state_e;

    function automatic logic [PERIOD_W-1:0] reset_period(input int unsigned layer);
        return RESET_PERIODS[layer*PERIOD_W +: PERIOD_W];
    endfunction

endpackage

// File: rtl/parallax_scroll_sequencer_if.sv
// Layer period configuration handshake between a host (master) and the sequencer (slave).
interface parallax_scroll_sequencer_if;
    import scroller_pkg::*;

    logic                cfg_valid;
    logic [IDX_W-1:0]    cfg_layer;
    logic [PERIOD_W-1:0] cfg_period;
    logic                cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_layer,
        output cfg_period,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_layer,
        input  cfg_period,
        output cfg_ready
    );

endinterface

// File: rtl/parallax_scroll_sequencer_layer_divider.sv
// Per-layer frame divider: on each evaluate strobe either steps and restarts, or counts up.
module layer_divider
    import scroller_pkg::*;
#(
    parameter logic [PERIOD_W-1:0] RstPeriod = '0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_load,
    input  logic [PERIOD_W-1:0] cfg_period,
    input  logic                eval,
    input  logic                hold,
    output logic                step
);

    logic [PERIOD_W-1:0] period_q;
    logic [PERIOD_W-1:0] count_q;
    logic                step_q;

    // cfg_load only occurs while idle and eval only while scanning, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_q <= RstPeriod;
            count_q  <= '0;
            step_q   <= 1'b0;
        end else begin
            step_q <= 1'b0;
            if (cfg_load) begin
                period_q <= cfg_period;
                count_q  <= '0;
            end else if (eval && !hold && (period_q != PERIOD_OFF)) begin
                if (count_q == period_q) begin
                    step_q  <= 1'b1;
                    count_q <= '0;
                end else begin
                    count_q <= count_q + 1'b1;
                end
            end
        end
    end

    assign step = step_q;

endmodule

// File: rtl/parallax_scroll_sequencer.sv
// Parallax scroll sequencer: each frame_tick walks all layer dividers once, one per cycle.
// Build option SCROLL_PAUSE_EN: when defined, pause freezes layer evaluation.
module parallax_scroll_sequencer #(
    parameter int unsigned NUM_LAYERS = scroller_pkg::NUM_LAYERS
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       frame_tick,
    parallax_scroll_sequencer_if.slave cfg,
    input  logic                       pause,
    output logic [NUM_LAYERS-1:0]      step,
    output logic                       busy,
    output logic                       overrun,
    output logic [7:0]                 frame_count
);
    import scroller_pkg::*;

    localparam int unsigned IdxW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    state_e          state_q;
    logic [IdxW-1:0] idx_q;
    logic            pending_q;
    logic            overrun_q;
    logic [7:0]      frame_count_q;

    logic scanning;
    logic last_layer;
    logic cfg_fire;
    logic hold;

    assign scanning   = (state_q == StScan);
    assign last_layer = (idx_q == IdxW'(NUM_LAYERS - 1));
    assign cfg_fire   = cfg.cfg_valid && cfg.cfg_ready;

`ifdef SCROLL_PAUSE_EN
    assign hold = pause;
`else
    logic unused_pause;
    assign unused_pause = pause;
    assign hold         = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            pending_q     <= 1'b0;
            overrun_q     <= 1'b0;
            frame_count_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (frame_tick) begin
                        state_q       <= StScan;
                        idx_q         <= '0;
                        frame_count_q <= frame_count_q + 8'd1;
                    end
                end
                StScan: begin
                    if (last_layer) begin
                        idx_q     <= '0;
                        pending_q <= 1'b0;
                        // A waiting frame (or a tick landing on the final edge) restarts
                        // the scan immediately without passing through idle.
                        if (pending_q || frame_tick) begin
                            frame_count_q <= frame_count_q + 8'd1;
                        end else begin
                            state_q <= StIdle;
                        end
                        if (pending_q && frame_tick) begin
                            overrun_q <= 1'b1;
                        end
                    end else begin
                        idx_q <= idx_q + 1'b1;
                        if (frame_tick) begin
                            if (pending_q) begin
                                overrun_q <= 1'b1;
                            end else begin
                                pending_q <= 1'b1;
                            end
                        end
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
        layer_divider #(
            .RstPeriod(reset_period(k))
        ) u_div (
            .clk       (clk),
            .rst_n     (rst_n),
            .cfg_load  (cfg_fire && (cfg.cfg_layer == IDX_W'(k))),
            .cfg_period(cfg.cfg_period),
            .eval      (scanning && (idx_q == IdxW'(k))),
            .hold      (hold),
            .step      (step[k])
        );
    end

    assign busy          = scanning;
    assign cfg.cfg_ready = (state_q == StIdle);
    assign overrun       = overrun_q;
    assign frame_count   = frame_count_q;

endmodule

// File: tb/tb_parallax_scroll_sequencer.sv
// Randomised and directed bench for parallax_scroll_sequencer against a frame-schedule model.
module tb_parallax_scroll_sequencer;
    import scroller_pkg::*;

    localparam int NL = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          frame_tick = 1'b0;
    logic          pause = 1'b0;
    logic [NL-1:0] step;
    logic          busy;
    logic          overrun;
    logic [7:0]    frame_count;

    parallax_scroll_sequencer_if cfg_if ();

    parallax_scroll_sequencer #(
        .NUM_LAYERS(NL)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame_tick (frame_tick),
        .cfg        (cfg_if.slave),
        .pause      (pause),
        .step       (step),
        .busy       (busy),
        .overrun    (overrun),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Model: a frame occupies the NL edges after its start edge; layer k is judged at
    // start+1+k.  Each layer remembers how many frames have passed since it last stepped.
    int            m_edge;
    int            m_start;
    bit            m_pend;
    bit            m_ovr;
    int            m_fc;
    int            m_per[NL];
    int            m_since[NL];
    logic [NL-1:0] m_step;

    int step_cnt[NL];
    int busy_cnt;

    task automatic model_reset();
        m_edge  = 0;
        m_start = -100;
        m_pend  = 1'b0;
        m_ovr   = 1'b0;
        m_fc    = 0;
        m_step  = '0;
        for (int k = 0; k < NL; k++) begin
            m_per[k]   = (1 << k) - 1;
            m_since[k] = 0;
        end
    endtask

    function automatic bit model_busy();
        int ph;
        ph = m_edge - m_start;
        return (ph >= 1) && (ph <= NL);
    endfunction

    task automatic start_frame();
        m_start = m_edge;
        m_fc    = (m_fc + 1) % 256;
    endtask

    task automatic model_edge(input bit tick, input bit v, input int l, input int p,
                              input bit pz);
        int ph;
        int k;
        bit hold;
        hold = 1'b0;
`ifdef SCROLL_PAUSE_EN
        hold = pz;
`endif
        m_step = '0;
        ph = m_edge - m_start;
        if (ph >= 1 && ph <= NL) begin
            k = ph - 1;
            if (m_per[k] != 15 && !hold) begin
                if (m_since[k] == m_per[k]) begin
                    m_step[k]  = 1'b1;
                    m_since[k] = 0;
                end else begin
                    m_since[k]++;
                end
            end
            if (ph == NL) begin
                if (m_pend && tick) m_ovr = 1'b1;
                if (m_pend || tick) start_frame();
                m_pend = 1'b0;
            end else if (tick) begin
                if (m_pend) m_ovr = 1'b1;
                else m_pend = 1'b1;
            end
        end else begin
            if (v) begin
                m_per[l]   = p;
                m_since[l] = 0;
            end
            if (tick) start_frame();
        end
        m_edge++;
    endtask

    task automatic check_outputs();
        check("step", step, m_step);
        check("busy", busy, model_busy());
        check("cfg_ready", cfg_if.cfg_ready, !model_busy());
        check("overrun", overrun, m_ovr);
        check("frame_count", frame_count, m_fc);
        check("step_onehot", ($countones(step) <= 1), 1);
    endtask

    task automatic clear_counts();
        for (int k = 0; k < NL; k++) step_cnt[k] = 0;
        busy_cnt = 0;
    endtask

    task automatic cycle(input bit tick, input bit v, input int l, input int p, input bit pz);
        @(negedge clk);
        frame_tick        = tick;
        cfg_if.cfg_valid  = v;
        cfg_if.cfg_layer  = 2'(l);
        cfg_if.cfg_period = 4'(p);
        pause             = pz;
        check("cfg_ready_pre", cfg_if.cfg_ready, !model_busy());
        @(posedge clk);
        model_edge(tick, v, l, p, pz);
        #1;
        check_outputs();
        for (int k = 0; k < NL; k++) step_cnt[k] += int'(step[k]);
        busy_cnt += int'(busy);
    endtask

    task automatic idle(input int n, input bit pz);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0, 0, pz);
    endtask

    task automatic frames(input int n, input int gap, input bit pz);
        for (int i = 0; i < n; i++) begin
            cycle(1'b1, 1'b0, 0, 0, pz);
            idle(gap - 1, pz);
        end
    endtask

    // Reset is asserted between clock edges to exercise its asynchronous path.
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n            = 1'b0;
        frame_tick       = 1'b0;
        cfg_if.cfg_valid = 1'b0;
        pause            = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit tick;
        bit v;
        int l;
        int p;
        bit pz;

        cfg_if.cfg_valid  = 1'b0;
        cfg_if.cfg_layer  = '0;
        cfg_if.cfg_period = '0;
        model_reset();
        #3;
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // One frame from reset: only layer 0 steps, on the edge after the start edge.
        clear_counts();
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        check("first_step0", step, 4'b0001);
        idle(8, 1'b0);
        check("first_busy_cycles", busy_cnt, 4);
        check("first_fc", frame_count, 1);
        check("first_step_total", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3], 1);

        // Eight spaced frames with reset periods.
        async_reset();
        clear_counts();
        frames(8, 10, 1'b0);
        check("div_l0", step_cnt[0], 8);
        check("div_l1", step_cnt[1], 4);
        check("div_l2", step_cnt[2], 2);
        check("div_l3", step_cnt[3], 1);

        // Layer 2 switched off.
        cycle(1'b0, 1'b1, 2, 15, 1'b0);
        clear_counts();
        frames(5, 10, 1'b0);
        check("off_l2", step_cnt[2], 0);
        check("off_l0", step_cnt[0], 5);

        // Back-to-back frame without overrun.
        async_reset();
        clear_counts();
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle(8, 1'b0);
        check("b2b_busy_cycles", busy_cnt, 8);
        check("b2b_overrun", overrun, 0);
        check("b2b_fc", frame_count, 2);

        // Third tick in the window overruns and is dropped.
        async_reset();
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        idle(8, 1'b0);
        check("ovr_set", overrun, 1);
        check("ovr_fc", frame_count, 2);
        idle(3, 1'b0);
        check("ovr_sticky", overrun, 1);

        // Config write coincident with a frame tick.
        async_reset();
        clear_counts();
        cycle(1'b1, 1'b1, 0, 2, 1'b0);
        idle(9, 1'b0);
        frames(1, 10, 1'b0);
        check("coinc_l0_f2", step_cnt[0], 0);
        frames(1, 10, 1'b0);
        check("coinc_l0_f3", step_cnt[0], 1);

        // Pause held across three frames.
        async_reset();
        clear_counts();
        frames(3, 10, 1'b1);
        check("pause_fc", frame_count, 3);
`ifdef SCROLL_PAUSE_EN
        check("pause_l0", step_cnt[0], 0);
`else
        check("pause_l0", step_cnt[0], 3);
`endif

        // Reset in the middle of a scan aborts it.
        async_reset();
        cycle(1'b1, 1'b0, 0, 0, 1'b0);
        cycle(1'b0, 1'b0, 0, 0, 1'b0);
        async_reset();
        clear_counts();
        idle(6, 1'b0);
        check("abort_no_steps", step_cnt[0] + step_cnt[1] + step_cnt[2] + step_cnt[3], 0);
        frames(1, 6, 1'b0);
        check("abort_restart_l0", step_cnt[0], 1);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 599) == 0) async_reset();
            tick = ($urandom_range(0, 6) == 0);
            v    = ($urandom_range(0, 3) == 0);
            l    = int'($urandom_range(0, NL - 1));
            p    = ($urandom_range(0, 5) == 0) ? 15 : int'($urandom_range(0, 14));
            pz   = ($urandom_range(0, 7) == 0);
            cycle(tick, v, l, p, pz);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
